// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from vga_sync_gen: pixel strobe, position, syncs and frame markers.
// master drives the timing; slave is any downstream text/graphics consumer.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start, frame_cnt
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: clock divider, pixel/line counters and registered sync decode.
// Define VGA_SYNC_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       x_q, y_q;
    logic [9:0]       x_nxt, y_nxt;
    logic             hsync_q, vsync_q, video_q, fstart_q;
    logic             p_tick, h_wrap, frame_wrap;

    assign p_tick = (div_q == DIV_MAX);

    // Next raster position; only taken on a pixel tick.
    always_comb begin
        h_wrap     = (x_q == H_MAX);
        frame_wrap = h_wrap && (y_q == V_MAX);
        x_nxt      = h_wrap ? 10'd0 : x_q + 10'd1;
        y_nxt      = y_q;
        if (h_wrap) begin
            y_nxt = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Syncs and blanking decode x_nxt/y_nxt so they move together with the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            video_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            div_q    <= p_tick ? '0 : div_q + 1'b1;
            fstart_q <= p_tick && frame_wrap;
            if (p_tick) begin
                x_q     <= x_nxt;
                y_q     <= y_nxt;
                hsync_q <= !((x_nxt >= HS_START) && (x_nxt <= HS_END));
                vsync_q <= !((y_nxt >= VS_START) && (y_nxt <= VS_END));
                video_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            end
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q <= 8'd0;
        end else if (p_tick && frame_wrap) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign vga.frame_cnt = fcnt_q;
`else
    assign vga.frame_cnt = 8'h00;
`endif

    assign vga.p_tick      = p_tick;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;
    assign vga.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small-raster instance and a default 640x480 instance
// checked every cycle against an arithmetic raster model, with random async resets.
`timescale 1ns/1ps
module tb_vga_sync_gen;
  localparam int S_D = 2, S_HD = 4, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VD = 3, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int D_D = 4, D_HD = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VD = 480, D_VF = 10, D_VS = 2, D_VB = 33;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint n;          // clk edges since the last reset release
  int     vectors = 0;
  int     miscompares = 0;
  bit     chk_en = 1'b0;
  bit     ph1 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  vga_sync_gen_if sm_if();
  vga_sync_gen_if df_if();

  vga_sync_gen #(
    .CLK_DIV(S_D), .H_DISPLAY(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_DISPLAY(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .vga (sm_if)
  );

  vga_sync_gen dut_dflt (
    .clk (clk),
    .rst (rst),
    .vga (df_if)
  );

  obs_t sm_obs, df_obs;
  assign sm_obs = {sm_if.p_tick, sm_if.pixel_x, sm_if.pixel_y, sm_if.hsync, sm_if.vsync,
                   sm_if.video_on, sm_if.frame_start, sm_if.frame_cnt};
  assign df_obs = {df_if.p_tick, df_if.pixel_x, df_if.pixel_y, df_if.hsync, df_if.vsync,
                   df_if.video_on, df_if.frame_start, df_if.frame_cnt};

  // ---------------- reference model ----------------
  // Position is simply (edges / CLK_DIV) pixel ticks into an endlessly repeating raster.
  function automatic obs_t model(input int d, input int h_d, input int h_f, input int h_s,
                                 input int h_b, input int v_d, input int v_f, input int v_s,
                                 input int v_b, input longint cyc);
    obs_t   e;
    int     ht;
    int     vt;
    longint frame;
    longint ticks;
    longint pos;
    int     x;
    int     y;
    ht    = h_d + h_f + h_s + h_b;
    vt    = v_d + v_f + v_s + v_b;
    frame = longint'(ht) * longint'(vt);
    ticks = cyc / d;
    pos   = ticks % frame;
    x     = int'(pos % ht);
    y     = int'(pos / ht);
    e.pt  = ((cyc % d) == d - 1);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = !(x >= h_d + h_f && x < h_d + h_f + h_s);
    e.vs  = !(y >= v_d + v_f && y < v_d + v_f + v_s);
    e.vo  = (ticks > 0) && (x < h_d) && (y < v_d);
    e.fs  = (cyc > 0) && ((cyc % d) == 0) && (ticks % frame == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    e.fc  = 8'((ticks / frame) % 256);
`else
    e.fc  = 8'h00;
`endif
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".p_tick"},      32'(a.pt), 32'(e.pt));
    chk({tag, ".pixel_x"},     32'(a.x),  32'(e.x));
    chk({tag, ".pixel_y"},     32'(a.y),  32'(e.y));
    chk({tag, ".hsync"},       32'(a.hs), 32'(e.hs));
    chk({tag, ".vsync"},       32'(a.vs), 32'(e.vs));
    chk({tag, ".video_on"},    32'(a.vo), 32'(e.vo));
    chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
    chk({tag, ".frame_cnt"},   32'(a.fc), 32'(e.fc));
  endtask

  task automatic check_both(input string tag);
    check_obs({tag, "/small"}, sm_obs,
              model(S_D, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, n));
    check_obs({tag, "/dflt"}, df_obs,
              model(D_D, D_HD, D_HF, D_HS, D_HB, D_VD, D_VF, D_VS, D_VB, n));
  endtask

  always @(negedge clk) begin
    if (chk_en) check_both("cycle");
  end

  // ---------------- aggregate monitors ----------------
  int          hs_low_cnt = 0;
  int          vs_low_cnt = 0;
  int          vo_cnt = 0;
  int          fs_cnt = 0;
  logic        prev_hs = 1'b1;
  logic [31:0] fall_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  fc_prev = 8'd0;
  logic [7:0]  fc_max = 8'd0;
  bit          wrap_seen = 1'b0;

  always @(negedge clk) begin
    if (ph1) begin
      if (n >= 4 && n <= 3203 && !df_if.hsync) hs_low_cnt++;
      if (prev_hs && !df_if.hsync) fall_q.push_back(32'(n));
      prev_hs = df_if.hsync;
      if (n >= 2 && n <= 97) begin
        if (!sm_if.vsync)   vs_low_cnt++;
        if (sm_if.video_on) vo_cnt++;
      end
      if (n >= 1 && n <= 960 && sm_if.frame_start) fs_cnt++;
    end
    if (rst) begin
      if (fc_prev == 8'd255 && sm_if.frame_cnt == 8'd0) wrap_seen = 1'b1;
      if (sm_if.frame_cnt > fc_max) fc_max = sm_if.frame_cnt;
      fc_prev = sm_if.frame_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b0;
    #1;
    check_both("async_rst");
    repeat (hold + 1) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_small_pixel(input int px, input int py);
    int k;
    k = 0;
    while (!(sm_if.pixel_x == 10'(px) && sm_if.pixel_y == 10'(py)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("small.reach_pixel", 32'(k < 200), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    rst = 1'b0;
    #1;
    check_both("por");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    ph1 = 1'b1;

    // First pixel tick of the default raster lands on edge 4.
    repeat (3) @(negedge clk);
    chk("dflt.p_tick_before_edge4", 32'(df_if.p_tick), 32'd1);
    chk("dflt.pixel_x_before_edge4", 32'(df_if.pixel_x), 32'd0);
    @(negedge clk);
    chk("dflt.pixel_x_after_edge4", 32'(df_if.pixel_x), 32'd1);
    chk("dflt.video_on_after_edge4", 32'(df_if.video_on), 32'd1);
    chk("dflt.p_tick_after_edge4", 32'(df_if.p_tick), 32'd0);

    repeat (7000 - 4) @(negedge clk);
    ph1 = 1'b0;
    chk("dflt.hsync_low_clks", 32'(hs_low_cnt), 32'd384);
    exp_q.push_back(32'd2624);
    exp_q.push_back(32'd5824);
    chk("dflt.hsync_fall_count", 32'(fall_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && fall_q.size() > 0)
      chk("dflt.hsync_fall_edge", fall_q.pop_front(), exp_q.pop_front());
    chk("small.vsync_low_clks", 32'(vs_low_cnt), 32'd16);
    chk("small.video_on_clks", 32'(vo_cnt), 32'd24);
    chk("small.frame_starts", 32'(fs_cnt), 32'd10);

    // Targeted mid-frame abort, then random reset storms.
    wait_small_pixel(6, 3);
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(40, 1500)) @(negedge clk);
      do_reset($urandom_range(0, 3));
    end

    // Long undisturbed run: more than 256 small frames.
    wrap_seen = 1'b0;
    fc_max = 8'd0;
    repeat (257 * 96 + 40) @(negedge clk);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("small.frame_cnt_wrap", 32'(wrap_seen), 32'd1);
    chk("small.frame_cnt_max", 32'(fc_max), 32'd255);
`else
    chk("small.frame_cnt_max", 32'(fc_max), 32'd0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
